debounce_sched: RTL and testbench

DEBOUNCE_SCHED -- requirements
Module: debounce_sched

---
 rtl/debounce_sched.sv | 133 +++++++++++++
 tb/tb_debounce_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_sched.sv
// debounce_sched: N-button debouncer sharing one round-robin-arbitrated 32-bit debounce timer
module debounce_sched #(
    parameter int          N               = 4,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd120000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn,
    output logic [N-1:0] toggle,
    output logic [N-1:0] press_pulse,
    output logic         busy,
    output logic [2:0]   owner
);

    typedef enum logic [1:0] {IDLE, REQ, HELD} btn_st_t;
    typedef enum logic {T_IDLE, T_RUN} tmr_st_t;

    localparam logic [2:0] LAST_RST = 3'(N - 1);

    logic [N-1:0] s1_q, s1_d, bs_q, bs_d;
    btn_st_t      st_q [N];
    btn_st_t      st_d [N];
    tmr_st_t      tst_q, tst_d;
    logic [31:0]  count_q, count_d;
    logic [N-1:0] toggle_q, toggle_d, pulse_q, pulse_d;
    logic         busy_q, busy_d, cool_q, cool_d;
    logic [2:0]   owner_q, owner_d, last_q, last_d;
    logic         gnt_found, grant, done, own, gnt;
    logic [2:0]   gnt_idx;
    int           j;

    assign toggle      = toggle_q;
    assign press_pulse = pulse_q;
    assign busy        = busy_q;
    assign owner       = owner_q;

    // Round-robin pick: first requesting button after last_owner
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        j         = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last_q) + k) % N;
            if (!gnt_found && st_q[j] == REQ) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'(j);
            end
        end
    end

    // Next-state logic; cool_q blocks a grant in the cycle right after a completion
    always_comb begin
        s1_d     = btn;
        bs_d     = s1_q;
        st_d     = st_q;
        tst_d    = tst_q;
        count_d  = count_q;
        toggle_d = toggle_q;
        pulse_d  = '0;
        busy_d   = busy_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cool_d   = 1'b0;
        own      = 1'b0;
        gnt      = 1'b0;
        done     = tst_q == T_RUN && count_q == DEBOUNCE_CYCLES - 32'd1;
        grant    = tst_q == T_IDLE && !cool_q && gnt_found;
        for (int i = 0; i < N; i++) begin
            own = tst_q == T_RUN && owner_q == 3'(i);
            gnt = grant && gnt_idx == 3'(i);
            case (st_q[i])
                IDLE: st_d[i] = bs_q[i] ? REQ : IDLE;
                REQ: begin
                    if (own && done) begin
                        st_d[i]     = bs_q[i] ? HELD : IDLE;
                        toggle_d[i] = toggle_q[i] ^ bs_q[i];
                        pulse_d[i]  = bs_q[i];
                    end else if (!own && !gnt && !bs_q[i]) begin
                        st_d[i] = IDLE;
                    end
                end
                HELD:    st_d[i] = bs_q[i] ? HELD : IDLE;
                default: st_d[i] = IDLE;
            endcase
        end
        if (tst_q == T_IDLE) begin
            count_d = 32'd0;
            if (grant) begin
                tst_d   = T_RUN;
                owner_d = gnt_idx;
                busy_d  = 1'b1;
            end
        end else if (done) begin
            tst_d   = T_IDLE;
            count_d = 32'd0;
            busy_d  = 1'b0;
            last_d  = owner_q;
            cool_d  = 1'b1;
        end else begin
            count_d = count_q + 32'd1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            bs_q     <= '0;
            for (int i = 0; i < N; i++) st_q[i] <= IDLE;
            tst_q    <= T_IDLE;
            count_q  <= 32'd0;
            toggle_q <= '0;
            pulse_q  <= '0;
            busy_q   <= 1'b0;
            owner_q  <= 3'd0;
            last_q   <= LAST_RST;
            cool_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            bs_q     <= bs_d;
            st_q     <= st_d;
            tst_q    <= tst_d;
            count_q  <= count_d;
            toggle_q <= toggle_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cool_q   <= cool_d;
        end
    end

endmodule

// File: tb/tb_debounce_sched.sv
// tb_debounce_sched: directed checks of debounce_sched with N=4, DEBOUNCE_CYCLES=8
module tb_debounce_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] toggle, press_pulse;
    logic       busy;
    logic [2:0] owner;

    int tests = 0;
    int fails = 0;
    int pc [4] = '{0, 0, 0, 0};
    int multi = 0;
    int p0, p3;

    debounce_sched #(.N(4), .DEBOUNCE_CYCLES(32'd8)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .toggle(toggle), .press_pulse(press_pulse), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Count pulses per button and flag any cycle with more than one pulse
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (press_pulse[i]) pc[i] = pc[i] + 1;
        if (!$onehot0(press_pulse)) multi = multi + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0000;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_toggle", 32'(toggle), 0);
        chk("rst_pulse", 32'(press_pulse), 0);
        cyc(3);
        rst_n = 1'b1;
        // single press, free timer
        btn = 4'b0001;
        cyc(3);
        chk("s1_busy_pre", 32'(busy), 0);
        cyc(1);
        chk("s1_busy", 32'(busy), 1);
        chk("s1_owner", 32'(owner), 0);
        cyc(7);
        chk("s1_pulse_early", 32'(press_pulse), 0);
        cyc(1);
        chk("s1_pulse", 32'(press_pulse), 4'b0001);
        chk("s1_toggle", 32'(toggle), 4'b0001);
        chk("s1_busy_done", 32'(busy), 0);
        cyc(1);
        chk("s1_pulse_one", 32'(press_pulse), 0);
        p0 = pc[0];
        cyc(20);
        chk("s1_held_nopulse", 32'(pc[0]), 32'(p0));
        chk("s1_held_idle", 32'(busy), 0);
        btn = 4'b0000;
        cyc(4);
        // glitch shorter than window
        btn = 4'b0010;
        cyc(3);
        btn = 4'b0000;
        cyc(1);
        chk("s2_busy", 32'(busy), 1);
        chk("s2_owner", 32'(owner), 1);
        cyc(8);
        chk("s2_busy_done", 32'(busy), 0);
        chk("s2_pulse", 32'(press_pulse), 0);
        chk("s2_toggle", 32'(toggle), 4'b0001);
        cyc(3);
        chk("s2_idle", 32'(busy), 0);
        chk("s2_pc1", 32'(pc[1]), 0);
        // reset, then all four together
        rst_n = 1'b0;
        #1;
        chk("r_toggle", 32'(toggle), 0);
        chk("r_busy", 32'(busy), 0);
        cyc(2);
        rst_n = 1'b1;
        btn = 4'b1111;
        cyc(4);
        chk("s3_owner0", 32'(owner), 0);
        chk("s3_busy0", 32'(busy), 1);
        cyc(8);
        chk("s3_pulse0", 32'(press_pulse), 4'b0001);
        for (int b = 1; b < 4; b++) begin
            cyc(1);
            chk("s3_cool", 32'(busy), 0);
            cyc(1);
            chk("s3_owner", 32'(owner), 32'(b));
            chk("s3_busy", 32'(busy), 1);
            cyc(8);
            chk("s3_pulse", 32'(press_pulse), 32'(4'b0001 << b));
        end
        chk("s3_toggle", 32'(toggle), 4'b1111);
        // release and re-press button 2
        cyc(3);
        btn = 4'b1011;
        cyc(3);
        btn = 4'b1111;
        cyc(4);
        chk("s4_owner", 32'(owner), 2);
        chk("s4_busy", 32'(busy), 1);
        cyc(8);
        chk("s4_pulse", 32'(press_pulse), 4'b0100);
        chk("s4_toggle", 32'(toggle), 4'b1011);
        // reset mid-count while button 3 owns the timer
        cyc(2);
        btn = 4'b0000;
        cyc(5);
        btn = 4'b1000;
        cyc(4);
        chk("s5_owner", 32'(owner), 3);
        chk("s5_busy", 32'(busy), 1);
        cyc(5);
        p3 = pc[3];
        rst_n = 1'b0;
        #1;
        chk("s5_rst_toggle", 32'(toggle), 0);
        chk("s5_rst_busy", 32'(busy), 0);
        chk("s5_rst_owner", 32'(owner), 0);
        chk("s5_rst_pulse", 32'(press_pulse), 0);
        cyc(2);
        chk("s5_aborted", 32'(pc[3]), 32'(p3));
        rst_n = 1'b1;
        cyc(4);
        chk("s5_regrant", 32'(owner), 3);
        chk("s5_regrant_busy", 32'(busy), 1);
        cyc(7);
        chk("s5_pulse_early", 32'(press_pulse), 0);
        cyc(1);
        chk("s5_pulse", 32'(press_pulse), 4'b1000);
        chk("s5_toggle", 32'(toggle), 4'b1000);
        cyc(10);
        chk("s5_once", 32'(pc[3]), 32'(p3 + 1));
        // round-robin after button 1 completes
        btn = 4'b0000;
        cyc(5);
        btn = 4'b0010;
        cyc(4);
        chk("s6_owner1", 32'(owner), 1);
        btn = 4'b0001;
        cyc(6);
        btn = 4'b0011;
        cyc(2);
        chk("s6_done_pulse", 32'(press_pulse), 0);
        chk("s6_done_busy", 32'(busy), 0);
        chk("s6_done_toggle", 32'(toggle), 4'b1000);
        cyc(2);
        chk("s6_rr_owner", 32'(owner), 0);
        chk("s6_rr_busy", 32'(busy), 1);
        cyc(8);
        chk("s6_pulse0", 32'(press_pulse), 4'b0001);
        chk("s6_toggle0", 32'(toggle), 4'b1001);
        cyc(2);
        chk("s6_owner_next", 32'(owner), 1);
        cyc(8);
        chk("s6_pulse1", 32'(press_pulse), 4'b0010);
        chk("s6_toggle1", 32'(toggle), 4'b1011);
        chk("onehot_pulse", 32'(multi), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
